ffp_write_arbiter: RTL
======================

Name: ffp_write_arbiter

Overview:
- Round-robin arbiter that shares one enable flip-flop register (clk/reset/enable/D/Q style, WIDTH bits) among N_REQ requesters.
- Each cycle it selects at most one requester and drives the register's enable and D inputs with that requester's data.
- A granted requester may keep the register for up to MAX_BURST consecutive writes, then ownership rotates.
- Sits between the requesting datapath blocks and the shared register instance.

Parameters:
N_REQ, 4, number of requesters (power of two, 2..8)
WIDTH, 4, data width of the shared register
MAX_BURST, 2, max consecutive grants to one owner while others wait (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous active-low reset: sampled on the rising edge of clk; 0 = reset
req  input  N_REQ  per-requester write request, level-sensitive
wdata  input  N_REQ*WIDTH  requester i data on bits [i*WIDTH +: WIDTH]
gnt  output  N_REQ  one-hot grant (registered); bit i high = requester i wrote this cycle
reg_en  output  1  enable to shared register (registered)
reg_d  output  WIDTH  D input to shared register (registered)
owner  output  clog2(N_REQ)  index of current/last owner
busy  output  1  OR of gnt

Behaviour:
- All outputs and state update only on rising clk; no asynchronous paths.
- Reset (reset==0 at edge):
  - gnt=0, reg_en=0, reg_d=0, owner=0, busy=0.
  - Round-robin pointer ptr=0, burst count cnt=0, state=IDLE.
  - Reset wins over every other condition, including mid-burst.
- State: IDLE (gnt==0) / GRANT (gnt one-hot). At each edge with reset==1, evaluate in priority order:
  - a) Continue: state==GRANT, req[owner]==1 and cnt<MAX_BURST.
    - Keep owner and gnt.
    - cnt=cnt+1, reg_en=1, reg_d=wdata[owner].
    - ptr unchanged.
  - b) New grant: otherwise, if any req bit is 1.
    - winner = first set req bit searching ptr, ptr+1, ... modulo N_REQ.
    - gnt=onehot(winner), owner=winner, cnt=1, reg_en=1, reg_d=wdata[winner].
    - ptr=(winner+1) mod N_REQ, state=GRANT.
  - c) Idle: otherwise gnt=0, reg_en=0, busy=0, state=IDLE.
    - reg_d and owner hold their previous values; cnt=0.
- Latency: a req/wdata value sampled at edge k appears on gnt/reg_en/reg_d after edge k. The shared register captures it at edge k+1.
- Data is resampled every granted cycle, so a burst writes the current wdata[owner] each cycle.
- Lone requester with burst exhausted: the search from ptr wraps back to the owner, so it is regranted with cnt=1. No idle bubble is inserted.
- Owner drops req mid-burst: rule (b) applies that same edge. There is no dead cycle if another req is pending.
- gnt is always zero or one-hot. reg_en==busy==|gnt at all times.
- Unused req bits above N_REQ do not exist. wdata of non-granted requesters is ignored.

Test Plan:
- Reset: reset=0 for 3 edges with req=1111 -> gnt=0000, reg_en=0, reg_d=0000, owner=0, busy=0 every cycle. First edge with reset=1 -> gnt=0001.
- Single requester: req=0001, wdata0=0101 held 5 edges -> gnt=0001 and reg_en=1 on all 5. reg_d=0101 throughout with no bubble at the burst boundary. Register Q=0101.
- Contention: from reset, req=1111, wdata0..3=0001,0010,0011,0100 held -> gnt sequence 0001,0001,0010,0010,0100,0100,1000,1000,0001. reg_d follows 0001,0001,0010,0010,0011,0011,0100,0100,0001.
- Early release: req=0101 from reset. Drop req0 after its first grant -> next gnt=0100, owner=2, reg_d=wdata2. Total writes to requester 0 = 1.
- Reset mid-burst: while gnt=0100, drive reset=0 for one edge -> all outputs 0. After release with req=1111 -> first gnt=0001, confirming ptr=0.
- Idle hold: after a grant with reg_d=0011, set req=0000 for 3 edges -> gnt=0000, reg_en=0, busy=0. reg_d stays 0011, owner unchanged, register Q unchanged.

Source files
------------

// File: rtl/ffp_write_arbiter.sv
// Round-robin write arbiter in front of one shared enable/D/Q register.
// An owner keeps the register for up to MAX_BURST consecutive writes, then it rotates.
module ffp_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 4,
    parameter int MAX_BURST = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     wdata,
    output logic [N_REQ-1:0]           gnt,
    output logic                       reg_en,
    output logic [WIDTH-1:0]           reg_d,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t         state;
    logic [IW-1:0]  ptr;
    logic [CW-1:0]  cnt;
    logic           found;
    logic [IW-1:0]  winner;
    logic           cont;

    assign cont = (state == GRANT) && req[owner] && (cnt < CW'(MAX_BURST));

    // Search starts at ptr; the IW-bit sum wraps modulo N_REQ because N_REQ is a power of two.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[ptr + IW'(i)]) begin
                found  = 1'b1;
                winner = ptr + IW'(i);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            ptr    <= '0;
            cnt    <= '0;
            gnt    <= '0;
            reg_en <= 1'b0;
            reg_d  <= '0;
            owner  <= '0;
            busy   <= 1'b0;
        end else if (cont) begin
            cnt    <= cnt + 1'b1;
            reg_en <= 1'b1;
            busy   <= 1'b1;
            reg_d  <= wdata[owner*WIDTH +: WIDTH];
        end else if (found) begin
            state  <= GRANT;
            gnt    <= {{(N_REQ-1){1'b0}}, 1'b1} << winner;
            owner  <= winner;
            cnt    <= CW'(1);
            reg_en <= 1'b1;
            busy   <= 1'b1;
            reg_d  <= wdata[winner*WIDTH +: WIDTH];
            ptr    <= winner + 1'b1;
        end else begin
            // Idle keeps reg_d and owner so the last write stays observable.
            state  <= IDLE;
            gnt    <= '0;
            reg_en <= 1'b0;
            busy   <= 1'b0;
            cnt    <= '0;
        end
    end

endmodule
